onehot_token_sink: RTL and testbench

ONEHOT_TOKEN_SINK -- requirements
Module: onehot_token_sink

---
 rtl/onehot_pkg.sv | 13 +
 rtl/onehot_seq_fifo.sv | 61 ++++++
 rtl/onehot_token_sink.sv | 89 ++++++++
 tb/tb_onehot_token_sink.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared defaults and FSM encoding for the token sink
package onehot_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int SEQ_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_seq_fifo.sv
// rtl/onehot_seq_fifo.sv - circular tag buffer with occupancy tracking
module onehot_seq_fifo
  import onehot_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [SEQ_W-1:0] wr_data,
  output logic [SEQ_W-1:0] rd_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [OCC_W-1:0] occ_next
);

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [SEQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Head of the buffer is always presented; it only moves on a pop.
  assign rd_data = mem[rd_ptr];

  // Next occupancy, shared with the FSM so both agree on full/empty transitions.
  always_comb begin
    occ_next = occupancy;
    if (push && !pop) begin
      occ_next = occupancy + OCC_ONE;
    end else if (pop && !push) begin
      occ_next = occupancy - OCC_ONE;
    end
  end

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      occupancy <= occ_next;
    end
  end

endmodule

// File: rtl/onehot_token_sink.sv
// rtl/onehot_token_sink.sv - buffers delay-line tokens, tags them, returns credits
module onehot_token_sink
  import onehot_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEQ_W = SEQ_W_DEF,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEQ_W-1:0] out_seq,
  output logic [OCC_W-1:0] occupancy,
  output logic             credit,
  output logic             overflow
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  state_t           state;
  logic [SEQ_W-1:0] seq_cnt;
  logic [OCC_W-1:0] occ_next;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // A full buffer still accepts a token when the head leaves on the same edge.
  assign pop     = out_valid && out_ready;
  assign push_ok = tok_in && ((state != ST_FULL) || pop);
  assign drop    = tok_in && (state == ST_FULL) && !pop;

  onehot_seq_fifo #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .pop       (pop),
    .wr_data   (seq_cnt),
    .rd_data   (out_seq),
    .occupancy (occupancy),
    .occ_next  (occ_next)
  );

  // Fill-level FSM plus tag counter, credit pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      seq_cnt   <= '0;
      out_valid <= 1'b0;
      credit    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      credit    <= pop;
      out_valid <= (occ_next != '0);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        seq_cnt <= seq_cnt + SEQ_ONE;
      end
      case (state)
        ST_EMPTY: begin
          if (push_ok) begin
            state <= ST_PARTIAL;
          end
        end
        ST_PARTIAL: begin
          if (occ_next == OCC_FULL) begin
            state <= ST_FULL;
          end else if (occ_next == '0) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop && !push_ok) begin
            state <= ST_PARTIAL;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_token_sink.sv
// tb/tb_onehot_token_sink.sv - self-checking bench for onehot_token_sink
module tb_onehot_token_sink;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             tok_in;
  logic             out_valid;
  logic             out_ready;
  logic [SEQ_W-1:0] out_seq;
  logic [OCC_W-1:0] occupancy;
  logic             credit;
  logic             overflow;

  onehot_token_sink #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_in    (tok_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seq   (out_seq),
    .occupancy (occupancy),
    .credit    (credit),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_first;
    bit tok;
    bit rdy;
    bit e_valid;
    int e_occ;
    int e_seq;
    bit e_credit;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   passed;

  // Reference model: a queue of tags in arrival order.
  int q[$];
  int m_seq;
  bit m_ovf;
  bit m_credit;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input bit rf, input bit t, input bit r, input bit v,
                     input int o, input int s, input bit c, input bit ov);
    vec_t e;
    e.rst_first = rf; e.tok = t; e.rdy = r; e.e_valid = v;
    e.e_occ = o; e.e_seq = s; e.e_credit = c; e.e_ovf = ov;
    vecs.push_back(e);
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0;
    m_ovf = 0;
    m_credit = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tok_in = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic drive(input bit t, input bit r);
    bit p;
    int sz;
    tok_in = t;
    out_ready = r;
    sz = q.size();
    p = (sz != 0) && r;
    if (p) void'(q.pop_front());
    if (t) begin
      if (sz < DEPTH || p) begin
        q.push_back(m_seq);
        m_seq = (m_seq + 1) % (1 << SEQ_W);
      end else begin
        m_ovf = 1;
      end
    end
    m_credit = p;
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, int'(out_valid), int'(q.size() != 0));
    chk({tag, " occ"}, int'(occupancy), q.size());
    if (q.size() != 0) chk({tag, " seq"}, int'(out_seq), q[0]);
    chk({tag, " credit"}, int'(credit), int'(m_credit));
    chk({tag, " ovf"}, int'(overflow), int'(m_ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    passed = 0;
    tok_in = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    #2;
    chk("reset valid", int'(out_valid), 0);
    chk("reset occ", int'(occupancy), 0);
    chk("reset seq", int'(out_seq), 0);
    chk("reset credit", int'(credit), 0);
    chk("reset ovf", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // rst_first, tok, rdy, valid, occ, seq, credit, ovf
    add(1, 1, 1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 2, 0, 0, 0);
    add(0, 1, 0, 1, 3, 0, 0, 0);
    add(0, 1, 0, 1, 4, 0, 0, 0);
    add(0, 1, 0, 1, 4, 0, 0, 1);
    add(0, 0, 1, 1, 3, 1, 1, 1);
    add(0, 0, 1, 1, 2, 2, 1, 1);
    add(0, 0, 1, 1, 1, 3, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 2, 0, 0, 0);
    add(0, 1, 0, 1, 3, 0, 0, 0);
    add(0, 1, 0, 1, 4, 0, 0, 0);
    add(0, 1, 1, 1, 4, 1, 1, 0);
    add(0, 0, 1, 1, 3, 2, 1, 0);
    add(0, 0, 1, 1, 2, 3, 1, 0);
    add(0, 0, 1, 1, 1, 4, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 1, 2, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      drive(vecs[i].tok, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), int'(out_valid), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d occ", i), int'(occupancy), vecs[i].e_occ);
      if (vecs[i].e_valid) chk($sformatf("vec%0d seq", i), int'(out_seq), vecs[i].e_seq);
      chk($sformatf("vec%0d credit", i), int'(credit), int'(vecs[i].e_credit));
      chk($sformatf("vec%0d ovf", i), int'(overflow), int'(vecs[i].e_ovf));
      check_model($sformatf("vec%0d model", i));
    end

    // Sequence wrap: stream 17 tokens straight through.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 1'b1);
      chk($sformatf("wrap%0d valid", k), int'(out_valid), 1);
      chk($sformatf("wrap%0d seq", k), int'(out_seq), k % 16);
      chk($sformatf("wrap%0d occ", k), int'(occupancy), 1);
    end
    drive(1'b0, 1'b1);
    chk("wrap drain credit", int'(credit), 1);
    chk("wrap drain occ", int'(occupancy), 0);

    // Reset mid-run with overflow set and tokens buffered.
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    chk("midrst pre occ", int'(occupancy), 4);
    chk("midrst pre ovf", int'(overflow), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst valid", int'(out_valid), 0);
    chk("midrst occ", int'(occupancy), 0);
    chk("midrst ovf", int'(overflow), 0);
    chk("midrst credit", int'(credit), 0);
    model_reset();
    tok_in = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst after credit", int'(credit), 0);
    drive(1'b1, 1'b0);
    chk("midrst first tag", int'(out_seq), 0);
    chk("midrst first valid", int'(out_valid), 1);
    check_model("midrst model");

    // Randomized traffic against the queue model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45);
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
